// File: rtl/mem_write_monitor_pkg.sv
// mem_write_monitor_pkg: shared types and default parameters for the store-bus monitor.
package mem_write_monitor_pkg;
    typedef enum logic [1:0] {RUN, PASS, FAIL} mon_state_e;
    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } trace_entry_t;
    localparam logic [31:0] DEF_PASS_ADR    = 32'd100;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEF_ALLOWED_ADR = 32'd96;
endpackage

// File: rtl/mon_fifo.sv
// mon_fifo: synchronous DEPTH-entry FIFO of trace entries; wrap bit on pointers separates full from empty.
module mon_fifo
    import mem_write_monitor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  trace_entry_t din_i,
    output trace_entry_t dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    trace_entry_t mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    // a pop frees the slot the push needs, so a full FIFO still accepts a write alongside a read
    assign do_push = push_i && (!full_o || do_pop);
    assign wr_d    = wr_q + (AW+1)'(do_push);
    assign rd_d    = rd_q + (AW+1)'(do_pop);
    assign dout_o  = mem_q[rd_q[AW-1:0]];
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/mem_write_monitor.sv
// mem_write_monitor: observes stores, flags pass/fail/timeout and logs every store in a FIFO.
// Define STRICT_ADDR_CHECK_EN to fail on stores outside PASS_ADR/ALLOWED_ADR.
module mem_write_monitor
    import mem_write_monitor_pkg::*;
#(
    parameter logic [31:0] PASS_ADR    = DEF_PASS_ADR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] ALLOWED_ADR = DEF_ALLOWED_ADR,
    parameter int          DEPTH       = 8,
    parameter int          TIMEOUT     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [31:0] rd_adr,
    output logic [31:0] rd_data,
    output logic        fifo_full,
    output logic        overflow,
    output logic [15:0] write_count,
    output logic        done,
    output logic        pass,
    output logic        fail
);
    localparam int CW = $clog2(TIMEOUT) + 1;
`ifdef STRICT_ADDR_CHECK_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    mon_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]  wc_q, wc_d;
    logic         ovf_q, ovf_d;
    logic         run, ev, at_pass, illegal, timeout, full, empty;
    trace_entry_t entry, head;
    assign run     = state_q == RUN;
    assign ev      = run && MemWrite;
    assign at_pass = Adr == PASS_ADR;
    assign illegal = STRICT && !at_pass && (Adr != ALLOWED_ADR);
    assign timeout = cnt_q == CW'(TIMEOUT - 1);
    assign entry   = '{adr: Adr, data: WriteData};
    always_comb begin
        state_d = state_q;
        if (run) state_d = (ev && at_pass && WriteData == PASS_DATA) ? PASS :
                           ((ev && (at_pass || illegal)) || timeout) ? FAIL : RUN;
        cnt_d = run ? cnt_q + 1'b1 : cnt_q;
        wc_d  = (ev && wc_q != 16'hFFFF) ? wc_q + 16'd1 : wc_q;
        ovf_d = ovf_q | (ev && full && !rd_en);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            wc_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wc_q    <= wc_d;
            ovf_q   <= ovf_d;
        end
    end
    mon_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_i (ev),
        .pop_i  (rd_en),
        .din_i  (entry),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );
    assign pass        = state_q == PASS;
    assign fail        = state_q == FAIL;
    assign done        = pass | fail;
    assign write_count = wc_q;
    assign overflow    = ovf_q;
    assign fifo_full   = full;
    assign rd_valid    = !empty;
    assign rd_adr      = head.adr;
    assign rd_data     = head.data;
endmodule

// File: tb/tb_mem_write_monitor.sv
// tb_mem_write_monitor: scoreboard bench; expected FIFO entries are queued as stores are driven.
module tb_mem_write_monitor;
    import mem_write_monitor_pkg::*;
    localparam int DEPTH = 8;
    localparam int TO    = 20;
    localparam logic [31:0] PA = 32'd100, PD = 32'd7, AA = 32'd96;
`ifdef STRICT_ADDR_CHECK_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    logic clk = 0, reset = 0, MemWrite = 0, rd_en = 0;
    logic [31:0] Adr = 0, WriteData = 0;
    logic rd_valid, fifo_full, overflow, done, pass, fail;
    logic [31:0] rd_adr, rd_data;
    logic [15:0] write_count;
    int vecs = 0, errs = 0;
    trace_entry_t exp_q[$];
    int m_state = 0, m_cnt = 0;
    logic [15:0] m_wc = 0;
    bit m_ovf = 0;

    always #5 clk = ~clk;

    mem_write_monitor #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_adr(rd_adr), .rd_data(rd_data),
        .fifo_full(fifo_full), .overflow(overflow), .write_count(write_count),
        .done(done), .pass(pass), .fail(fail)
    );

    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic re);
        bit ev;
        ev = (m_state == 0) && mw;
        MemWrite = mw; Adr = a; WriteData = d; rd_en = re;
        if (re && exp_q.size() > 0) void'(exp_q.pop_front());
        if (ev) begin
            if (m_wc != 16'hFFFF) m_wc++;
            if (exp_q.size() < DEPTH) exp_q.push_back('{adr: a, data: d});
            else m_ovf = 1;
        end
        if (m_state == 0) begin
            if (ev && a == PA && d == PD) m_state = 1;
            else if ((ev && (a == PA || (STRICT && a != AA))) || m_cnt == TO - 1) m_state = 2;
            m_cnt++;
        end
        @(posedge clk); #1;
        MemWrite = 0; rd_en = 0;
    endtask

    task automatic do_reset();
        reset = 1; MemWrite = 0; rd_en = 0;
        @(posedge clk); #1;
        reset = 0;
        exp_q.delete(); m_state = 0; m_cnt = 0; m_wc = 0; m_ovf = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if ({done, pass, fail, fifo_full, overflow, rd_valid, write_count} !== 22'd0) begin
            errs++;
            $display("FAIL reset: outputs=%b want all zero", {done, pass, fail, fifo_full, overflow, rd_valid, write_count});
        end
    endtask

    task automatic test_pass();
        do_reset();
        step(1, 96, 3, 0);
        vecs++;
        if (pass !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL pass_early: pass=%b done=%b want 0 0", pass, done); end
        step(1, 100, 7, 0);
        vecs++;
        if (pass !== 1'b1 || done !== 1'b1 || fail !== 1'b0) begin errs++; $display("FAIL pass_flag: pass=%b done=%b fail=%b want 1 1 0", pass, done, fail); end
        vecs++;
        if (write_count !== m_wc) begin errs++; $display("FAIL pass_wc: got %0d want %0d", write_count, m_wc); end
        while (exp_q.size() > 0) begin
            vecs++;
            if (rd_valid !== 1'b1 || rd_adr !== exp_q[0].adr || rd_data !== exp_q[0].data) begin
                errs++; $display("FAIL pass_pop: got v=%b (%0d,%0d) want (%0d,%0d)", rd_valid, rd_adr, rd_data, exp_q[0].adr, exp_q[0].data);
            end
            step(0, 0, 0, 1);
        end
        vecs++;
        if (rd_valid !== 1'b0) begin errs++; $display("FAIL pass_empty: rd_valid=%b want 0", rd_valid); end
    endtask

    task automatic test_fail();
        do_reset();
        step(1, 100, 5, 0);
        vecs++;
        if (fail !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin errs++; $display("FAIL fail_flag: fail=%b pass=%b done=%b want 1 0 1", fail, pass, done); end
        step(1, 100, 7, 0);
        vecs++;
        if (fail !== 1'b1 || pass !== 1'b0 || write_count !== 16'd1) begin
            errs++; $display("FAIL fail_sticky: fail=%b pass=%b wc=%0d want 1 0 1", fail, pass, write_count);
        end
        while (exp_q.size() > 0) begin
            vecs++;
            if (rd_valid !== 1'b1 || rd_adr !== exp_q[0].adr || rd_data !== exp_q[0].data) begin
                errs++; $display("FAIL fail_pop: got v=%b (%0d,%0d) want (%0d,%0d)", rd_valid, rd_adr, rd_data, exp_q[0].adr, exp_q[0].data);
            end
            step(0, 0, 0, 1);
        end
        vecs++;
        if (rd_valid !== 1'b0) begin errs++; $display("FAIL fail_empty: rd_valid=%b want 0", rd_valid); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < TO - 1; i++) step(0, 0, 0, 0);
        vecs++;
        if (fail !== 1'b0) begin errs++; $display("FAIL timeout_early: fail=%b want 0", fail); end
        step(0, 0, 0, 0);
        vecs++;
        if (fail !== 1'b1 || pass !== 1'b0 || done !== 1'b1) begin errs++; $display("FAIL timeout_flag: fail=%b pass=%b done=%b want 1 0 1", fail, pass, done); end
        vecs++;
        if (write_count !== 16'd0 || rd_valid !== 1'b0) begin errs++; $display("FAIL timeout_idle: wc=%0d rd_valid=%b want 0 0", write_count, rd_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 96, 32'(i + 10), 0);
        vecs++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin errs++; $display("FAIL ovf_full8: full=%b ovf=%b want 1 0", fifo_full, overflow); end
        step(1, 96, 99, 0);
        vecs++;
        if (overflow !== 1'b1 || fifo_full !== 1'b1 || write_count !== 16'd9) begin
            errs++; $display("FAIL ovf_9th: ovf=%b full=%b wc=%0d want 1 1 9", overflow, fifo_full, write_count);
        end
        vecs++;
        if (rd_adr !== exp_q[0].adr || rd_data !== exp_q[0].data) begin
            errs++; $display("FAIL ovf_head: got (%0d,%0d) want (%0d,%0d)", rd_adr, rd_data, exp_q[0].adr, exp_q[0].data);
        end
        step(1, 96, 77, 1);
        vecs++;
        if (fifo_full !== 1'b1 || write_count !== m_wc) begin
            errs++; $display("FAIL ovf_poppush: full=%b wc=%0d want 1 %0d", fifo_full, write_count, m_wc);
        end
        while (exp_q.size() > 0) begin
            vecs++;
            if (rd_valid !== 1'b1 || rd_adr !== exp_q[0].adr || rd_data !== exp_q[0].data) begin
                errs++; $display("FAIL ovf_pop: got v=%b (%0d,%0d) want (%0d,%0d)", rd_valid, rd_adr, rd_data, exp_q[0].adr, exp_q[0].data);
            end
            step(0, 0, 0, 1);
        end
        vecs++;
        if (rd_valid !== 1'b0 || overflow !== m_ovf) begin errs++; $display("FAIL ovf_end: rd_valid=%b ovf=%b want 0 %b", rd_valid, overflow, m_ovf); end
    endtask

    task automatic test_strict();
        do_reset();
        step(1, 104, 1, 0);
        vecs++;
        if (fail !== STRICT || pass !== 1'b0) begin errs++; $display("FAIL strict_104: fail=%b pass=%b want %b 0", fail, pass, STRICT); end
        step(1, 100, 7, 0);
        vecs++;
        if (pass !== !STRICT || fail !== STRICT || write_count !== m_wc) begin
            errs++; $display("FAIL strict_then: pass=%b fail=%b wc=%0d want %b %b %0d", pass, fail, write_count, !STRICT, STRICT, m_wc);
        end
        while (exp_q.size() > 0) begin
            vecs++;
            if (rd_valid !== 1'b1 || rd_adr !== exp_q[0].adr || rd_data !== exp_q[0].data) begin
                errs++; $display("FAIL strict_pop: got v=%b (%0d,%0d) want (%0d,%0d)", rd_valid, rd_adr, rd_data, exp_q[0].adr, exp_q[0].data);
            end
            step(0, 0, 0, 1);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(1, 96, 1, 0);
        step(1, 96, 2, 0);
        step(1, 200, 3, 0);
        do_reset();
        vecs++;
        if ({done, pass, fail, fifo_full, overflow, rd_valid, write_count} !== 22'd0) begin
            errs++; $display("FAIL midreset: outputs=%b want all zero", {done, pass, fail, fifo_full, overflow, rd_valid, write_count});
        end
        step(1, 100, 7, 0);
        vecs++;
        if (pass !== 1'b1 || write_count !== 16'd1) begin errs++; $display("FAIL midreset_pass: pass=%b wc=%0d want 1 1", pass, write_count); end
        vecs++;
        if (rd_valid !== 1'b1 || rd_adr !== 32'd100 || rd_data !== 32'd7) begin
            errs++; $display("FAIL midreset_head: v=%b (%0d,%0d) want 1 (100,7)", rd_valid, rd_adr, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_overflow();
        test_strict();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
